// File: rtl/coherency_snoop_engine_if.sv
// Bus bundle between the MESI snoop engine (master) and the L1 cores plus memory/L2 (slave).
interface coherency_snoop_engine_if #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 8
);
  localparam int LINE_BITS = 32 * LINE_WORDS;

  logic [NUM_CORES-1:0]            req_valid;
  logic [NUM_CORES-1:0]            req_ready;
  logic [NUM_CORES*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_CORES*2-1:0]          req_type;
  logic [NUM_CORES-1:0]            rsp_valid;
  logic [NUM_CORES-1:0]            rsp_ready;
  logic [1:0]                      rsp_state;
  logic [LINE_BITS-1:0]            rsp_data;
  logic [NUM_CORES-1:0]            snoop_valid;
  logic [NUM_CORES-1:0]            snoop_ready;
  logic [ADDR_WIDTH-1:0]           snoop_addr;
  logic                            snoop_inv;
  logic [NUM_CORES-1:0]            snoop_rsp_valid;
  logic [NUM_CORES-1:0]            snoop_rsp_hit;
  logic [NUM_CORES-1:0]            snoop_rsp_dirty;
  logic [NUM_CORES*LINE_BITS-1:0]  snoop_rsp_data;
  logic                            mem_req_valid;
  logic                            mem_req_ready;
  logic                            mem_req_we;
  logic [ADDR_WIDTH-1:0]           mem_req_addr;
  logic [LINE_BITS-1:0]            mem_req_wdata;
  logic                            mem_rsp_valid;
  logic [LINE_BITS-1:0]            mem_rsp_rdata;

  modport master (
    input  req_valid, req_addr, req_type, rsp_ready, snoop_ready,
           snoop_rsp_valid, snoop_rsp_hit, snoop_rsp_dirty, snoop_rsp_data,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output req_ready, rsp_valid, rsp_state, rsp_data, snoop_valid, snoop_addr,
           snoop_inv, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

  modport slave (
    output req_valid, req_addr, req_type, rsp_ready, snoop_ready,
           snoop_rsp_valid, snoop_rsp_hit, snoop_rsp_dirty, snoop_rsp_data,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  req_ready, rsp_valid, rsp_state, rsp_data, snoop_valid, snoop_addr,
           snoop_inv, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/coherency_snoop_engine.sv
// Central MESI snoop controller: round-robin grant, snoop broadcast, c2c forward or memory fetch.
// Optional performance counters are enabled by defining COH_PERF_CNT_EN.
module coherency_snoop_engine #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  coherency_snoop_engine_if.master bus,
  output logic [31:0]              perf_snoops,
  output logic [31:0]              perf_c2c
);
  localparam int LINE_BITS = 32 * LINE_WORDS;
  localparam int ID_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SNOOP, S_MEM_WB, S_MEM_RD, S_RESP} state_t;
  typedef enum logic [1:0] {RD_SHARED = 2'd0, RD_UNIQUE = 2'd1, UPGRADE = 2'd2} req_kind_t;
  typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_t;

  state_t               state, state_nxt;
  logic [ID_W-1:0]      rr_ptr, req_id, grant_id, cyc_dirty_id, dirty_id;
  logic                 grant_any, cyc_dirty_any, hit_acc, dirty_acc, hit_n, dirty_n;
  logic                 snoop_done, mem_issued;
  logic [NUM_CORES-1:0] grant_onehot, req_onehot, pending, waiting, snoop_fire, rsp_take;
  logic [ADDR_WIDTH-1:0] cap_addr;
  req_kind_t            cap_type;
  mesi_t                rsp_state_q;
  logic [LINE_BITS-1:0] line_data;

  function automatic logic [ID_W-1:0] wrap_id(input int v);
    return ID_W'(v % NUM_CORES);
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    // Walk downward so the last hit is the first requester at or after the pointer.
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap_id(int'(rr_ptr) + k)]) begin
        grant_any = 1'b1;
        grant_id  = wrap_id(int'(rr_ptr) + k);
      end
    end
  end

  assign grant_onehot = NUM_CORES'(1) << grant_id;
  assign req_onehot   = NUM_CORES'(1) << req_id;

  // A snoop response counts in its handshake cycle or later; stray strobes are masked.
  assign snoop_fire = pending & bus.snoop_ready;
  assign rsp_take   = (state == S_SNOOP) ?
                      (waiting & bus.snoop_rsp_valid & (~pending | bus.snoop_ready)) : '0;
  assign snoop_done = ((waiting & ~rsp_take) == '0);
  assign hit_n      = hit_acc | (|(rsp_take & bus.snoop_rsp_hit));
  assign dirty_n    = dirty_acc | cyc_dirty_any;

  always_comb begin
    cyc_dirty_any = 1'b0;
    cyc_dirty_id  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (rsp_take[i] && bus.snoop_rsp_dirty[i]) begin
        cyc_dirty_any = 1'b1;
        cyc_dirty_id  = ID_W'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_any) state_nxt = S_SNOOP;
      S_SNOOP: if (snoop_done) begin
        if (cap_type == UPGRADE)        state_nxt = S_RESP;
        else if (!dirty_n)              state_nxt = S_MEM_RD;
        else if (cap_type == RD_SHARED) state_nxt = S_MEM_WB;
        else                            state_nxt = S_RESP;
      end
      S_MEM_WB, S_MEM_RD: if (mem_issued && bus.mem_rsp_valid) state_nxt = S_RESP;
      S_RESP:  if (|(bus.rsp_ready & req_onehot)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready     = '0;
    bus.snoop_valid   = '0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.rsp_valid     = '0;
    case (state)
      S_IDLE:   if (grant_any && !rst) bus.req_ready = grant_onehot;
      S_SNOOP:  bus.snoop_valid = pending;
      S_MEM_WB: begin
        bus.mem_req_valid = !mem_issued;
        bus.mem_req_we    = 1'b1;
      end
      S_MEM_RD: bus.mem_req_valid = !mem_issued;
      S_RESP:   bus.rsp_valid = req_onehot;
      default:  ;
    endcase
  end

  assign bus.snoop_addr    = cap_addr;
  assign bus.snoop_inv     = (cap_type != RD_SHARED);
  assign bus.mem_req_addr  = cap_addr;
  assign bus.mem_req_wdata = line_data;
  assign bus.rsp_state     = rsp_state_q;
  assign bus.rsp_data      = line_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      req_id      <= '0;
      cap_addr    <= '0;
      cap_type    <= RD_SHARED;
      pending     <= '0;
      waiting     <= '0;
      hit_acc     <= 1'b0;
      dirty_acc   <= 1'b0;
      dirty_id    <= '0;
      mem_issued  <= 1'b0;
      rsp_state_q <= MESI_I;
      line_data   <= '0;
    end else begin
      case (state)
        S_IDLE: if (grant_any) begin
          req_id     <= grant_id;
          rr_ptr     <= wrap_id(int'(grant_id) + 1);
          cap_addr   <= bus.req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
          cap_type   <= (bus.req_type[grant_id*2 +: 2] == 2'd3) ? RD_SHARED
                                                                 : req_kind_t'(bus.req_type[grant_id*2 +: 2]);
          pending    <= ~grant_onehot;
          waiting    <= ~grant_onehot;
          hit_acc    <= 1'b0;
          dirty_acc  <= 1'b0;
          mem_issued <= 1'b0;
        end
        S_SNOOP: begin
          pending   <= pending & ~snoop_fire;
          waiting   <= waiting & ~rsp_take;
          hit_acc   <= hit_n;
          dirty_acc <= dirty_n;
          // Keep the lowest-index dirty responder even when it answers after a higher one.
          if (cyc_dirty_any && (!dirty_acc || cyc_dirty_id < dirty_id)) begin
            dirty_id  <= cyc_dirty_id;
            line_data <= bus.snoop_rsp_data[cyc_dirty_id*LINE_BITS +: LINE_BITS];
          end
          if (snoop_done) begin
            if (cap_type == UPGRADE)        rsp_state_q <= MESI_M;
            else if (dirty_n)               rsp_state_q <= (cap_type == RD_SHARED) ? MESI_S : MESI_M;
            else if (cap_type == RD_SHARED) rsp_state_q <= hit_n ? MESI_S : MESI_E;
            else                            rsp_state_q <= MESI_E;
          end
        end
        S_MEM_WB, S_MEM_RD: begin
          if (!mem_issued && bus.mem_req_ready) mem_issued <= 1'b1;
          if (state == S_MEM_RD && mem_issued && bus.mem_rsp_valid) line_data <= bus.mem_rsp_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef COH_PERF_CNT_EN
  localparam bit HAS_PEERS = (NUM_CORES > 1);
  logic [31:0] snoops_q, c2c_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      snoops_q <= '0;
      c2c_q    <= '0;
    end else if (state == S_SNOOP && snoop_done) begin
      if (HAS_PEERS && snoops_q != 32'hFFFF_FFFF) snoops_q <= snoops_q + 32'd1;
      if (cap_type != UPGRADE && dirty_n && c2c_q != 32'hFFFF_FFFF) c2c_q <= c2c_q + 32'd1;
    end
  end

  assign perf_snoops = snoops_q;
  assign perf_c2c    = c2c_q;
`else
  assign perf_snoops = '0;
  assign perf_c2c    = '0;
`endif
endmodule
